// File: rtl/sync_fifo_rd_stream.sv
// sync_fifo_rd_stream: drains a sync_fifo through its rd_en/rd_data/empty
// port and re-presents the words as a valid/ready stream. A 3-entry skid
// buffer absorbs the FIFO's one-cycle read latency, so reads are issued from
// registered occupancy alone and m_ready never reaches fifo_rd_en.
module sync_fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    logic                  run;
    logic                  inflight;
    logic [1:0]            occ;
    logic [1:0]            head;
    logic [1:0]            tail;
    logic [DATA_WIDTH-1:0] buf_mem [3];
    logic                  push;
    logic                  pop;

    // Pointers walk 0,1,2,0 ... over the three buffer slots.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Run flag keeps reads off for the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // Issue a read only when the word it returns is guaranteed a slot:
    // buffered words plus the one in flight must stay below three.
    always_comb begin
        fifo_rd_en = 1'b0;
        if (run && !flush && !fifo_empty &&
            (({1'b0, occ} + {2'b00, inflight}) < 3'd3)) begin
            fifo_rd_en = 1'b1;
        end
    end

    assign m_valid = (occ != 2'd0);
    assign m_data  = buf_mem[head];
    assign pop     = m_valid && m_ready;
    assign push    = inflight && !flush;

    // Occupancy, pointers and the in-flight marker; flush drops everything
    // held here, including the word returning from the FIFO this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            occ      <= 2'd0;
            head     <= 2'd0;
            tail     <= 2'd0;
        end else begin
            inflight <= fifo_rd_en;
            if (flush) begin
                occ  <= 2'd0;
                head <= 2'd0;
                tail <= 2'd0;
            end else begin
                if (push) begin
                    tail <= ptr_inc(tail);
                end
                if (pop) begin
                    head <= ptr_inc(head);
                end
                if (push && !pop) begin
                    occ <= occ + 2'd1;
                end else if (pop && !push) begin
                    occ <= occ - 2'd1;
                end
            end
        end
    end

    // Capture the FIFO read data into the tail slot one cycle after the read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                buf_mem[i] <= '0;
            end
        end else if (push) begin
            buf_mem[tail] <= fifo_rd_data;
        end
    end

    // Handshake counter; wraps freely, and a handshake in a flush cycle counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else begin
            word_cnt <= word_cnt + {{(CNT_WIDTH-1){1'b0}}, pop};
        end
    end

endmodule

// File: tb/tb_sync_fifo_rd_stream.sv
// Bench for sync_fifo_rd_stream: a queue-based sync_fifo model feeds the DUT,
// and a word-custody model (every word read from the FIFO is owed to the sink
// in order unless flushed or reset) scores the stream cycle by cycle.
module tb_sync_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data = 8'h00;
    logic        fifo_empty = 1'b1;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready;
    logic        flush;
    logic [15:0] word_cnt;

    logic        wr_req;
    logic [7:0]  wr_data;
    logic        preload_req;

    int          n_checks = 0;
    int          n_fail   = 0;

    sync_fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .flush        (flush),
        .word_cnt     (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  fifo_q[$];
    logic [7:0]  hold[$];
    logic        inflight_m = 1'b0;
    logic        run_m = 1'b0;
    logic [15:0] exp_cnt = 16'h0000;
    logic [7:0]  nxt_rd_data = 8'h00;
    logic        nxt_empty = 1'b1;
    logic        have_prev = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic        force_on = 1'b0;
    logic [7:0]  w;
    logic        exp_rd;
    logic        exp_v;

    // FIFO model outputs change on the rising edge like a real sync_fifo.
    always @(posedge clk) begin
        fifo_rd_data <= nxt_rd_data;
        fifo_empty   <= nxt_empty;
    end

    // Sample 1ns before each rising edge and apply that edge's effects.
    always begin
        @(negedge clk);
        #4;
        if (force_on) begin
            release dut.word_cnt;
            force_on = 1'b0;
        end
        if (!rst_n) begin
            chk("rst_rd_en", fifo_rd_en, 1'b0);
            chk("rst_valid", m_valid, 1'b0);
            chk("rst_cnt", word_cnt, 16'h0000);
            hold.delete();
            inflight_m = 1'b0;
            run_m      = 1'b0;
            exp_cnt    = 16'h0000;
            have_prev  = 1'b0;
        end else begin
            exp_rd = run_m && !flush && !fifo_empty && (hold.size() < 3);
            exp_v  = hold.size() > int'(inflight_m);
            chk("rd_en", fifo_rd_en, exp_rd);
            chk("m_valid", m_valid, exp_v);
            chk("word_cnt", word_cnt, exp_cnt);
            if (have_prev) chk("hold_stable", m_data, prev_data);
            if (m_valid && m_ready) begin
                if (hold.size() > 0) begin
                    chk("stream_order", m_data, hold[0]);
                    void'(hold.pop_front());
                end else begin
                    chk("spurious_word", 1'b1, 1'b0);
                end
                exp_cnt = exp_cnt + 16'h0001;
            end
            have_prev = m_valid && !m_ready && !flush;
            prev_data = m_data;
            if (flush) hold.delete();
            if (fifo_rd_en) begin
                chk("rd_while_empty", (fifo_q.size() > 0), 1'b1);
                if (fifo_q.size() > 0) begin
                    w = fifo_q.pop_front();
                    nxt_rd_data = w;
                    hold.push_back(w);
                end
            end
            inflight_m = fifo_rd_en;
            run_m = 1'b1;
            if (preload_req) begin
                force dut.word_cnt = 16'hFFFE;
                exp_cnt  = 16'hFFFE;
                force_on = 1'b1;
            end
        end
        if (wr_req) fifo_q.push_back(wr_data);
        nxt_empty = (fifo_q.size() == 0);
    end

    // ---------------- stimulus ----------------
    logic [7:0]  vec [8];
    logic [7:0]  fw  [9];
    logic [15:0] wrap_seq [3];
    logic [15:0] cnt0;
    int          t_rd, t_v, n_hs, last_hs, n_rd, k, n_wr, idle_run;
    logic        found, prev_hs;

    task automatic wait_idle(input string tag);
        idle_run = 0;
        for (int c = 0; c < 200 && idle_run < 4; c++) begin
            @(negedge clk);
            if (!m_valid && fifo_empty && !fifo_rd_en) idle_run++;
            else idle_run = 0;
        end
        chk(tag, (idle_run >= 4), 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = 8'h24; vec[1] = 8'h81; vec[2] = 8'h09; vec[3] = 8'h63;
        vec[4] = 8'h0D; vec[5] = 8'h8D; vec[6] = 8'h65; vec[7] = 8'h12;
        wrap_seq[0] = 16'hFFFF; wrap_seq[1] = 16'h0000; wrap_seq[2] = 16'h0001;
        rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0;
        wr_req = 1'b0; wr_data = 8'h00; preload_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_m_data", m_data, 8'h00);
        rst_n = 1'b1;

        // idle with an empty FIFO
        repeat (20) @(negedge clk);
        chk("idle_rd_en", fifo_rd_en, 1'b0);
        chk("idle_cnt", word_cnt, 16'h0000);

        // 8-word burst, sink always ready
        m_ready = 1'b1; t_rd = -1; t_v = -1; n_hs = 0; last_hs = -1;
        for (int c = 0; c < 40; c++) begin
            if (fifo_rd_en && t_rd < 0) t_rd = c;
            if (m_valid && t_v < 0) t_v = c;
            if (m_valid) begin
                chk("burst_word", m_data, vec[n_hs & 7]);
                n_hs++;
                last_hs = c;
            end
            wr_req  = (c < 8);
            wr_data = vec[c & 7];
            @(negedge clk);
        end
        wr_req = 1'b0;
        chk("burst_latency", t_v - t_rd, 2);
        chk("burst_count", n_hs, 8);
        chk("burst_no_bubble", last_hs - t_v, 7);
        chk("burst_cnt", word_cnt, 16'd8);

        // backpressure: buffer fills to three, then drains in order
        m_ready = 1'b0; n_rd = 0;
        for (int c = 0; c < 20; c++) begin
            if (fifo_rd_en) n_rd++;
            wr_req  = (c < 8);
            wr_data = vec[c & 7];
            @(negedge clk);
        end
        wr_req = 1'b0;
        chk("bp_rd_pulses", n_rd, 3);
        chk("bp_occ", dut.occ, 2'd3);
        chk("bp_valid", m_valid, 1'b1);
        chk("bp_head_data", m_data, 8'h24);
        m_ready = 1'b1; k = 0;
        for (int c = 0; c < 40; c++) begin
            if (m_valid) begin
                chk("bp_word", m_data, vec[k & 7]);
                k++;
            end
            @(negedge clk);
        end
        chk("bp_count", k, 8);
        chk("bp_cnt", word_cnt, 16'd16);

        // flush with two buffered words and one in flight
        m_ready = 1'b0;
        for (int i = 0; i < 9; i++) fw[i] = 8'($urandom);
        for (int c = 0; c < 17; c++) begin
            wr_req  = (c < 9);
            wr_data = fw[(c < 9) ? c : 0];
            @(negedge clk);
        end
        wr_req = 1'b0;
        chk("fl_pre_occ", dut.occ, 2'd3);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        @(negedge clk);
        chk("fl_occ", dut.occ, 2'd2);
        chk("fl_inflight", dut.inflight, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_valid_drop", m_valid, 1'b0);
        m_ready = 1'b1; k = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (m_valid) begin
                chk("fl_word", m_data, fw[4 + (k % 5)]);
                k++;
            end
        end
        chk("fl_count", k, 5);

        // random sink readiness with concurrent FIFO writes
        cnt0 = exp_cnt; n_wr = 0;
        for (int c = 0; c < 40; c++) begin
            m_ready = 1'($urandom_range(0, 1));
            wr_req  = 1'($urandom_range(0, 1));
            wr_data = 8'($urandom);
            if (wr_req) n_wr++;
            @(negedge clk);
        end
        wr_req = 1'b0; m_ready = 1'b1;
        wait_idle("rand_drain");
        chk("rand_cnt", word_cnt, cnt0 + 16'(n_wr));

        // asynchronous reset in the middle of a burst
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            wr_req  = (c < 6);
            wr_data = 8'($urandom);
            @(negedge clk);
            if (m_valid && fifo_rd_en) found = 1'b1;
        end
        wr_req = 1'b0;
        chk("rst_burst_found", found, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", m_valid, 1'b0);
        chk("rst_async_rd_en", fifo_rd_en, 1'b0);
        chk("rst_async_cnt", word_cnt, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle("rst_drain");

        // counter wrap from a preloaded value
        m_ready = 1'b0;
        @(negedge clk);
        preload_req = 1'b1;
        @(negedge clk);
        preload_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wrap_preload", word_cnt, 16'hFFFE);
        m_ready = 1'b1; k = 0; prev_hs = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (prev_hs) begin
                chk("wrap_seq", word_cnt, wrap_seq[k % 3]);
                k++;
            end
            prev_hs = m_valid && m_ready;
            wr_req  = (c < 3);
            wr_data = 8'($urandom);
            @(negedge clk);
        end
        wr_req = 1'b0;
        chk("wrap_count", k, 3);
        chk("wrap_final", word_cnt, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_rd_stream.md
Name: sync_fifo_rd_stream

Overview:
- Read-side drain engine for sync_fifo.
- Pulls words through the FIFO's rd_en/rd_data/empty port and presents them as a valid/ready stream to a downstream consumer.
- Absorbs the FIFO's one-cycle read latency with a 3-entry internal buffer, so back-to-back throughput is sustained with no combinational path from m_ready to fifo_rd_en.
- Sits between sync_fifo and any stream sink (UART tx, packetiser, etc.).

Parameters:
- DATA_WIDTH, 8, word width; must match the sync_fifo DATA_WIDTH.
- CNT_WIDTH, 16, width of the transferred-word counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fifo_rd_en  output  1  read strobe to sync_fifo rd_en.
- fifo_rd_data  input  DATA_WIDTH  sync_fifo rd_data; valid the cycle after fifo_rd_en.
- fifo_empty  input  1  sync_fifo empty.
- m_valid  output  1  stream word available.
- m_data  output  DATA_WIDTH  stream word.
- m_ready  input  1  sink accepts the word when m_valid && m_ready at a rising edge.
- flush  input  1  synchronous discard of buffered and in-flight words.
- word_cnt  output  CNT_WIDTH  count of completed stream handshakes.

Behaviour:
- Reset: clock and reset are as already decided (one clock clk; asynchronous active-low rst_n). While rst_n is low:
  - m_valid=0, m_data=0, word_cnt=0.
  - Internal occupancy occ=0, in-flight flag inflight=0.
  - fifo_rd_en=0, forced by a registered run flag that sets on the first clk edge after rst_n deasserts. First read is possible in the 2nd cycle after release.
- Read issue:
  - fifo_rd_en = run && !flush && !fifo_empty && (occ + inflight < 3).
  - It depends only on registered state and fifo_empty; never on m_ready.
  - inflight <= fifo_rd_en each cycle.
- Capture: when inflight=1 (and no flush this cycle), fifo_rd_data is written into the buffer tail at the clock edge.
- Buffer:
  - 3-entry circular buffer with 2-bit head/tail pointers wrapping 2->0, plus occ in 0..3.
  - Capture and pop in the same cycle leave occ unchanged.
  - The bound occ+inflight<=3 guarantees no overflow; overflow is unreachable.
- Stream output:
  - m_valid = (occ != 0); m_data = buffer[head]. Both are registered/derived from registers, with no combinational path from inputs.
  - Pop on m_valid && m_ready; head advances.
  - m_data holds stable while m_valid && !m_ready (AXI-style: once valid, data never changes until accepted).
- Latency and throughput:
  - fifo_rd_en high in cycle T -> word captured at end of T+1 -> m_valid high in T+2.
  - Steady state with m_ready=1 and FIFO non-empty: one word per cycle, occ=1, inflight=1.
- Backpressure: m_ready=0 lets occ fill to 3, after which fifo_rd_en deasserts. No word is lost or duplicated.
- fifo_empty:
  - Reading stops the same cycle fifo_empty is high.
  - Words already in flight or in the buffer still drain.
- flush (1 cycle or longer):
  - At the edge: occ=0, pointers=0, inflight=0; the in-flight word is discarded.
  - fifo_rd_en=0 while flush=1.
  - m_valid=0 the cycle after flush.
  - A handshake occurring in the flush cycle still counts in word_cnt.
  - The FIFO contents themselves are not touched.
- word_cnt: increments by 1 per handshake, wraps modulo 2^CNT_WIDTH (0xFFFF -> 0x0000), no saturation.
- Reset mid-operation: all state returns to reset values asynchronously. Any word in flight is lost, and fifo_rd_en drops immediately.

Test Plan:
- Reset then idle, fifo_empty=1 -> fifo_rd_en=0, m_valid=0, word_cnt=0 for 20 cycles. Reset asserted mid-burst -> m_valid and fifo_rd_en drop in the same cycle.
- Write 8 words (0x24,0x81,0x09,0x63,0x0D,0x8D,0x65,0x12) into sync_fifo with m_ready=1 -> stream emits the same 8 words in order, back-to-back after the first word (no bubbles), first m_valid 2 cycles after the first fifo_rd_en, word_cnt=8.
- 8 words queued, m_ready=0 -> exactly 3 fifo_rd_en pulses, occ=3, m_data=0x24 held stable. Then m_ready=1 -> all 8 words out in order, none duplicated.
- Random m_ready (50%) with simultaneous FIFO writes for 40 cycles -> output sequence equals write sequence per scoreboard, FIFO never read while empty, word_cnt equals handshake count.
- Flush while occ=2 and inflight=1 -> next cycle m_valid=0. Remaining FIFO words (e.g., 5) then stream correctly; the 3 flushed words never appear.
- Preload word_cnt near wrap (force 0xFFFE), send 3 words -> word_cnt sequence 0xFFFF, 0x0000, 0x0001.
